sevenseg_scan_driver: RTL and testbench
=======================================

# sevenseg_scan_driver

Parametrised, time-multiplexed seven-segment display driver for N BCD/hex digits. Captures a packed digit vector and decimal-point mask on a `ready` strobe into a shadow register. Scans digits at a programmable refresh rate, with optional leading-zero blanking and selectable output polarity. It sits between the BCD conversion stage and the board display pins, and replaces the fixed four-digit driver.

## Interface
- `NUM_DIGITS`, 4: digits driven, legal range 1..8.
- `REFRESH_DIV`, 50000: clock cycles each digit stays enabled, ≥1.
- `HEX_EN`, 0: 1 shows codes 10–15 as A,b,C,d,E,F; 0 shows them as a dash (segment g only).
- `BLANK_LZ`, 1: enables leading-zero blanking.
- `SEG_ACTIVE_LOW`, 1: inverts `segments` and `dp`.
- `AN_ACTIVE_LOW`, 1: inverts `digit_sel`.

Ports:
- `clk` input 1: single system clock, all logic on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `digits_in` input 4*NUM_DIGITS: packed digit codes; bits [3:0] are digit 0 (units), [7:4] are digit 1, and so on.
- `dp_in` input NUM_DIGITS: decimal-point mask; bit i belongs to digit i.
- `ready` input 1: load strobe; `digits_in` and `dp_in` are captured on any rising edge where it is 1.
- `segments` output 7: {g,f,e,d,c,b,a}, registered.
- `dp` output 1: decimal point of the active digit, registered.
- `digit_sel` output NUM_DIGITS: one-hot digit enable (before polarity), registered.
- `frame_tick` output 1: one-cycle pulse when the scan index wraps from NUM_DIGITS-1 to 0.

## Operation
- Shadow register:
  - Holds `shadow_digits` and `shadow_dp`; reset value is all zero.
  - Loaded when `ready`=1. If `ready` is held high, the shadow follows the inputs every cycle.
  - The display always reads from the shadow, never directly from the inputs.
- Prescaler: counter `pre` of width $clog2(REFRESH_DIV) (min 1) counts 0..REFRESH_DIV-1, then wraps.
  - On the wrap cycle, scan index `idx` advances: idx+1, or 0 if idx = NUM_DIGITS-1.
  - When REFRESH_DIV = 1, `idx` advances every cycle.
- Scan state is (`idx`, `pre`); there is no other FSM. Reset sets both to 0.
- Decode of code c, raw active-high {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - with HEX_EN=1: A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - with HEX_EN=0: codes 10–15 = 1000000
- Blanking (BLANK_LZ=1): digit i>0 is blanked when shadow digits i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked.
  - A blanked digit drives `digit_sel` all-inactive, segments inactive, and dp inactive, even if its dp_in bit is set.
- Polarity: the raw active-high segments, dp and one-hot select are XORed with their ACTIVE_LOW parameters at the output register input.

## Timing
- Reset (asynchronous assert on `rst`=0):
  - Outputs go immediately to inactive levels: `segments`/`dp` = all-1 if SEG_ACTIVE_LOW, else 0; `digit_sel` = all-1 if AN_ACTIVE_LOW, else 0; `frame_tick` = 0.
  - Reset mid-scan discards the shadow contents and the scan position.
- Release: reset release is synchronised by the clock. The first rising edge after `rst` goes high drives digit 0, showing the shadow value 0.
- Load latency: with `ready`=1 at edge k, the shadow is updated at k and the outputs reflect the new value at edge k+1 for whichever digit is active.
- Scan: the outputs follow `idx` with one cycle of register latency. Each digit is shown for exactly REFRESH_DIV cycles; one frame is NUM_DIGITS*REFRESH_DIV cycles.
- `frame_tick`: asserted for the single cycle after the edge where `idx` wraps to 0, aligned with digit 0 appearing on the outputs.
- Simultaneous events: `ready` on the same edge as an `idx` step is legal. The next output shows the new digit position decoded from the new shadow.
- Width rule: input codes are 4-bit unsigned. No arithmetic is performed on them; out-of-range codes are handled only by the decode rule above.

## Test plan
Use NUM_DIGITS=4, REFRESH_DIV=4, default polarities.
- Reset:
  - Stimulus: hold `rst`=0 for 3 cycles with random inputs, assert `ready` during reset, then release.
  - Required: `segments`=7'h7F, `digit_sel`=4'hF throughout reset. At the first edge after release, `digit_sel`=4'b1110 and `segments`=~7'b0111111.
- Load 7609 with dp_in=4'b0100:
  - Stimulus: pulse `ready` for 1 cycle.
  - Required over one frame: digit 0 shows 9, digit 1 shows 0 (not blanked), digit 2 shows 6 with dp=0 (active), digit 3 shows 7, each for 4 cycles.
  - Required: `frame_tick` fires every 16 cycles.
- Load 0094:
  - Required: digit 3 and digit 2 have `digit_sel`=4'hF during their slots; digits 1 and 0 show 9 and 4.
  - Then load 0000: only digit 0 lights, showing 0.
- Invalid codes:
  - Stimulus: load digit code 4'hB with HEX_EN=0.
  - Required: that slot shows a dash (~7'b1000000).
  - Rerun with HEX_EN=1: the slot shows b (~7'b1111100).
- Collision and hold:
  - Stimulus: assert `ready` on the same edge as an `idx` step; separately, hold `ready` high while `digits_in` changes each cycle.
  - Required: the next output uses the new shadow; the display tracks the input with one-cycle latency.
- Mid-scan reset:
  - Stimulus: assert `rst` in the middle of digit 2's slot.
  - Required: outputs go inactive asynchronously. After release, the scan restarts at digit 0 showing 0.

Source files
------------

// File: rtl/sevenseg_scan_driver_if.sv
//==============================================================================
// Module      : sevenseg_scan_driver_if
// Description : Load bus of the seven-segment scan driver. It carries the
//               packed digit codes, the decimal-point mask and the load strobe.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface sevenseg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    ready;

    modport master (output digits_in, output dp_in, output ready);
    modport slave  (input  digits_in, input  dp_in, input  ready);
endinterface

`default_nettype wire

// File: rtl/sevenseg_scan_driver.sv
//==============================================================================
// Module      : sevenseg_scan_driver
// Description : Time-multiplexed seven-segment driver for NUM_DIGITS hex/BCD
//               digits. It has a shadow register loaded on ready, a prescaled
//               scan index, optional leading-zero blanking and configurable
//               output polarity. All outputs are registered.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sevenseg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int HEX_EN         = 0,
    parameter int BLANK_LZ       = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,        // asynchronous, active low
    sevenseg_scan_driver_if.slave      load_bus,
    output logic [6:0]                 segments,   // {g,f,e,d,c,b,a}
    output logic                       dp,
    output logic [NUM_DIGITS-1:0]      digit_sel,
    output logic                       frame_tick
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;

    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] SEL_INV  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]            DASH     = 7'b1000000;

    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [PRE_W-1:0]        pre;
    logic [IDX_W-1:0]        idx;
    logic                    wrap_d;      // idx wrapped to 0 on the previous edge

    logic                    pre_wrap;
    logic                    idx_wrap;
    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic [NUM_DIGITS-1:0]   lz_zero;     // bit i: digits i..top are all zero
    logic [6:0]              seg_dec;

    assign pre_wrap = (pre == PRE_LAST);
    assign idx_wrap = (idx == IDX_LAST);

    // Shadow register: captures the load bus whenever ready is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
        end else if (load_bus.ready) begin
            shadow_digits <= load_bus.digits_in;
            shadow_dp     <= load_bus.dp_in;
        end
    end

    // Scan state: prescaler, digit index and a delayed wrap flag for frame_tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre    <= '0;
            idx    <= '0;
            wrap_d <= 1'b0;
        end else begin
            pre    <= pre_wrap ? '0 : pre + 1'b1;
            if (pre_wrap) begin
                idx <= idx_wrap ? '0 : idx + 1'b1;
            end
            wrap_d <= pre_wrap && idx_wrap;
        end
    end

    // Leading-zero map, built from the most significant digit downwards.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_zero  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero   = all_zero && (shadow_digits[4*i +: 4] == 4'd0);
            lz_zero[i] = all_zero;
        end
    end

    // Select the active digit's code, dp bit, one-hot enable and blank flag.
    always_comb begin
        cur_code   = 4'd0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_code      = shadow_digits[4*i +: 4];
                cur_dp        = shadow_dp[i];
                sel_onehot[i] = 1'b1;
                cur_blank     = (i != 0) && (BLANK_LZ != 0) && lz_zero[i];
            end
        end
    end

    // Active-high segment decode; codes 10-15 show letters or a dash.
    always_comb begin
        seg_dec = DASH;
        case (cur_code)
            4'h0: seg_dec = 7'b0111111;
            4'h1: seg_dec = 7'b0000110;
            4'h2: seg_dec = 7'b1011011;
            4'h3: seg_dec = 7'b1001111;
            4'h4: seg_dec = 7'b1100110;
            4'h5: seg_dec = 7'b1101101;
            4'h6: seg_dec = 7'b1111101;
            4'h7: seg_dec = 7'b0000111;
            4'h8: seg_dec = 7'b1111111;
            4'h9: seg_dec = 7'b1101111;
            4'hA: seg_dec = (HEX_EN != 0) ? 7'b1110111 : DASH;
            4'hB: seg_dec = (HEX_EN != 0) ? 7'b1111100 : DASH;
            4'hC: seg_dec = (HEX_EN != 0) ? 7'b0111001 : DASH;
            4'hD: seg_dec = (HEX_EN != 0) ? 7'b1011110 : DASH;
            4'hE: seg_dec = (HEX_EN != 0) ? 7'b1111001 : DASH;
            4'hF: seg_dec = (HEX_EN != 0) ? 7'b1110001 : DASH;
            default: seg_dec = DASH;
        endcase
    end

    // Output register: a blanked digit drives everything inactive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            segments   <= SEG_INV;
            dp         <= DP_INV;
            digit_sel  <= SEL_INV;
            frame_tick <= 1'b0;
        end else begin
            if (cur_blank) begin
                segments  <= SEG_INV;
                dp        <= DP_INV;
                digit_sel <= SEL_INV;
            end else begin
                segments  <= seg_dec ^ SEG_INV;
                dp        <= cur_dp ^ DP_INV;
                digit_sel <= sel_onehot ^ SEL_INV;
            end
            frame_tick <= wrap_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_scan_driver.sv
//==============================================================================
// Module      : tb_sevenseg_scan_driver
// Description : Scoreboard bench for sevenseg_scan_driver (4 digits, refresh
//               divider 4). Stimulus pushes per-cycle expectations; a monitor
//               on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sevenseg_scan_driver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sevenseg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

    logic [6:0] seg0, seg1;
    logic       dp0, dp1, ft0, ft1;
    logic [3:0] sel0, sel1;

    sevenseg_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(0), .BLANK_LZ(1),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .load_bus(bus),
        .segments(seg0), .dp(dp0), .digit_sel(sel0), .frame_tick(ft0)
    );

    sevenseg_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1), .BLANK_LZ(1),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut_hex (
        .clk(clk), .rst(rst), .load_bus(bus),
        .segments(seg1), .dp(dp1), .digit_sel(sel1), .frame_tick(ft1)
    );

    typedef struct {
        int         cyc;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] sel;
        logic       ft;
        bit         hex;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   c0 = 0;           // cycle count at the last reset release
    int   n_cmp = 0;
    int   n_err = 0;
    logic [15:0] sh_d;      // expected shadow contents
    logic [3:0]  sh_dp;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference display for one digit position, from the decode table.
    function automatic logic [11:0] ref_out(logic [15:0] sd, logic [3:0] sdp, int d, bit hex);
        logic [3:0] code;
        logic [6:0] raw;
        logic [3:0] one;
        code = sd[4*d +: 4];
        case (code)
            4'h0: raw = 7'b0111111;
            4'h1: raw = 7'b0000110;
            4'h2: raw = 7'b1011011;
            4'h3: raw = 7'b1001111;
            4'h4: raw = 7'b1100110;
            4'h5: raw = 7'b1101101;
            4'h6: raw = 7'b1111101;
            4'h7: raw = 7'b0000111;
            4'h8: raw = 7'b1111111;
            4'h9: raw = 7'b1101111;
            4'hA: raw = hex ? 7'b1110111 : 7'b1000000;
            4'hB: raw = hex ? 7'b1111100 : 7'b1000000;
            4'hC: raw = hex ? 7'b0111001 : 7'b1000000;
            4'hD: raw = hex ? 7'b1011110 : 7'b1000000;
            4'hE: raw = hex ? 7'b1111001 : 7'b1000000;
            default: raw = hex ? 7'b1110001 : 7'b1000000;
        endcase
        one = 4'b0001;
        one = one << d;
        if (d > 0 && (sd >> (4*d)) == 16'h0)
            return {7'h7F, 1'b1, 4'hF};
        return {~raw, ~sdp[d], ~one};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int x);
        while (cyc < x) tick();
    endtask

    task automatic push_inactive(int x);
        exp_t e;
        e.cyc = x; e.seg = 7'h7F; e.dp = 1'b1; e.sel = 4'hF; e.ft = 1'b0; e.hex = 1'b0;
        q.push_back(e);
    endtask

    // Expectations for cycles from..to, derived from the scan position.
    task automatic push_range(int from, int to, bit both);
        exp_t e;
        int   p;
        for (int x = from; x <= to; x++) begin
            p = (x - c0 - 1) % 16;
            for (int h = 0; h <= (both ? 1 : 0); h++) begin
                {e.seg, e.dp, e.sel} = ref_out(sh_d, sh_dp, p / 4, h != 0);
                e.cyc = x;
                e.ft  = (p == 0) && ((x - c0 - 1) >= 16);
                e.hex = (h != 0);
                q.push_back(e);
            end
        end
    endtask

    function automatic int next_frame(int t);
        int x;
        x = t;
        while (((x - c0 - 1) % 16) != 0) x++;
        return x;
    endfunction

    // One-cycle load pulse; returns just after the sampling edge.
    task automatic load(logic [15:0] d, logic [3:0] dpv);
        bus.digits_in = d;
        bus.dp_in     = dpv;
        bus.ready     = 1'b1;
        tick();
        bus.ready     = 1'b0;
        sh_d  = d;
        sh_dp = dpv;
    endtask

    task automatic check_load(logic [15:0] d, logic [3:0] dpv, bit both);
        int start;
        load(d, dpv);
        start = next_frame(cyc + 1);
        push_range(start, start + 16, both);
        wait_until(start + 16);
    endtask

    // Monitor: compare every expectation due on this cycle.
    exp_t        mon_e;
    logic [12:0] got, want;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            n_cmp++;
            if (mon_e.cyc < cyc) begin
                n_err++;
                $display("FAIL missed_slot cyc=%0d now=%0d", mon_e.cyc, cyc);
            end else begin
                got  = mon_e.hex ? {seg1, dp1, sel1, ft1} : {seg0, dp0, sel0, ft0};
                want = {mon_e.seg, mon_e.dp, mon_e.sel, mon_e.ft};
                if (got !== want) begin
                    n_err++;
                    $display("FAIL display cyc=%0d hex=%0d got seg=%b dp=%b sel=%b ft=%b want seg=%b dp=%b sel=%b ft=%b",
                             cyc, mon_e.hex, got[12:6], got[5], got[4:1], got[0],
                             want[12:6], want[5], want[4:1], want[0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
        $fatal(1, "timeout");
    end

    initial begin
        int x;
        int lastp;
        // Reset with random inputs and ready asserted throughout.
        rst = 1'b0;
        bus.ready     = 1'b1;
        bus.digits_in = 16'($urandom);
        bus.dp_in     = 4'($urandom);
        sh_d  = 16'h0;
        sh_dp = 4'h0;
        for (int k = 1; k <= 3; k++) push_inactive(k);
        while (cyc < 3) begin
            tick();
            bus.digits_in = 16'($urandom);
            bus.dp_in     = 4'($urandom);
        end
        rst       = 1'b1;
        bus.ready = 1'b0;
        c0        = cyc;
        push_range(c0 + 1, c0 + 16, 1'b0);
        wait_until(c0 + 16);

        // Directed loads, each checked over a full frame plus the next tick.
        check_load(16'h7609, 4'b0100, 1'b0);
        check_load(16'h0094, 4'b0000, 1'b0);
        check_load(16'h0000, 4'b0010, 1'b0);
        check_load(16'h00B0, 4'b0000, 1'b1);

        // Load sampled on the same edge as an idx step.
        while (((cyc - c0) % 4) != 3) tick();
        x = cyc + 1;
        push_range(x, x, 1'b0);
        load(16'h8888, 4'b0000);
        push_range(x + 1, x + 4, 1'b0);
        wait_until(x + 4);

        // ready held high while the input changes every cycle.
        lastp = cyc;
        for (int k = 1; k <= 6; k++) begin
            bus.digits_in = {4{4'(k)}};
            bus.dp_in     = 4'(k);
            bus.ready     = 1'b1;
            tick();
            sh_d  = bus.digits_in;
            sh_dp = bus.dp_in;
            push_range(cyc + 1, cyc + 1, 1'b0);
            lastp = cyc + 1;
        end
        bus.ready = 1'b0;
        wait_until(lastp + 1);

        // Reset asserted in the middle of digit 2's slot.
        while (((cyc - c0 - 1) % 16) != 9) tick();
        rst   = 1'b0;
        sh_d  = 16'h0;
        sh_dp = 4'h0;
        push_inactive(cyc);
        tick();
        push_inactive(cyc);
        tick();
        push_inactive(cyc);
        rst = 1'b1;
        c0  = cyc;
        push_range(c0 + 1, c0 + 8, 1'b0);
        wait_until(c0 + 8);
        tick();
        tick();

        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain pending=%0d required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
